// File: rtl/alu_cmd_link.sv
// alu_cmd_link
//   Byte-serial command front end for the combinational 32-bit ALU.
//   Receives a frame {opcode, A (MSB first), B (MSB first)} and drives the
//   ALU inputs for EXEC_CYCLES cycles. It then samples F/ovf/zero and returns
//   a response {flags, F (MSB first)} on the tx byte stream.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   rx_data/rx_valid/rx_ready  inbound command bytes (valid/ready)
//   tx_data/tx_valid/tx_ready  outbound response bytes (valid/ready)
//   alu_m, alu_s, alu_a, alu_b registered operands to the ALU
//   alu_f, alu_ovf, alu_zero   ALU result and flags
//   busy                       frame in progress (first rx byte .. last tx byte)
module alu_cmd_link #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1,
    parameter int MAX_OP      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [1:0]        alu_m,
    output logic [1:0]        alu_s,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_ovf,
    input  logic              alu_zero,
    output logic              busy
);

    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [2:0] {RX_OP, RX_A, RX_B, EXEC, TX} state_t;

    state_t            state;
    logic [7:0]        cnt;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] f_q;     // remaining result bytes, MSB byte next out

    logic              rx_acc;
    logic              tx_acc;
    logic              illegal;
    logic [DATA_W-1:0] a_shift;
    logic [DATA_W-1:0] b_shift;

    assign rx_acc  = rx_valid && rx_ready;
    assign tx_acc  = tx_valid && tx_ready;
    // Judged on the code actually presented to the ALU.
    assign illegal = (32'({alu_m, alu_s}) > 32'(MAX_OP));
    assign a_shift = (a_q << 8) | DATA_W'(rx_data);
    assign b_shift = (b_q << 8) | DATA_W'(rx_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RX_OP;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= '0;
            rx_ready <= 1'b1;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            alu_m    <= '0;
            alu_s    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
        end else begin
            case (state)
                RX_OP: begin
                    if (rx_acc) begin
                        op_q  <= rx_data[3:0];
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= RX_A;
                    end
                end
                RX_A: begin
                    if (rx_acc) begin
                        a_q <= a_shift;
                        if (cnt == 8'(NBYTES - 1)) begin
                            cnt   <= '0;
                            state <= RX_B;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                RX_B: begin
                    if (rx_acc) begin
                        b_q <= b_shift;
                        if (cnt == 8'(NBYTES - 1)) begin
                            // Operands go straight to the ALU on the same
                            // edge, so EXEC counts whole cycles of stable input.
                            cnt      <= '0;
                            state    <= EXEC;
                            rx_ready <= 1'b0;
                            alu_m    <= op_q[3:2];
                            alu_s    <= op_q[1:0];
                            alu_a    <= a_q;
                            alu_b    <= b_shift;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 8'(EXEC_CYCLES - 1)) begin
                        cnt      <= '0;
                        state    <= TX;
                        tx_valid <= 1'b1;
                        if (illegal) begin
                            tx_data <= 8'h04;
                            f_q     <= '0;
                        end else begin
                            tx_data <= {6'b0, alu_ovf, alu_zero};
                            f_q     <= alu_f;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                TX: begin
                    if (tx_acc) begin
                        if (cnt == 8'(NBYTES)) begin
                            cnt      <= '0;
                            state    <= RX_OP;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            rx_ready <= 1'b1;
                        end else begin
                            tx_data <= f_q[DATA_W-1 -: 8];
                            f_q     <= f_q << 8;
                            cnt     <= cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= RX_OP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_link.sv
module tb_alu_cmd_link;

    localparam int DATA_W = 32;
    localparam int NB     = DATA_W / 8;
    localparam int EC     = 3;
    localparam int FLEN   = 1 + 2 * NB;
    localparam int RLEN   = 1 + NB;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic [1:0]        alu_m, alu_s;
    logic [DATA_W-1:0] alu_a, alu_b, alu_f;
    logic              alu_ovf, alu_zero, busy;

    int nvec = 0;
    int nerr = 0;
    int last_wait = 0;

    always #5 clk = ~clk;

    alu_cmd_link #(.DATA_W(DATA_W), .EXEC_CYCLES(EC), .MAX_OP(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .alu_m(alu_m), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_zero(alu_zero), .busy(busy)
    );

    // Bench ALU: always an adder.
    always_comb begin
        alu_f    = alu_a + alu_b;
        alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
        alu_zero = (alu_f == '0);
    end

    // Expected response {flags, F} from the frame contents, using wide signed math.
    function automatic logic [8*RLEN-1:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint    s;
        logic [31:0] f;
        logic      ovf;
        s   = longint'($signed(a)) + longint'($signed(b));
        f   = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (int'(op[3:0]) > 10) return {8'h04, 32'h0};
        return {6'b0, ovf, (f == 32'h0), f};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int w;
        rx_data  = b;
        rx_valid = 1'b1;
        w = 0;
        while (!rx_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        last_wait = w;
        if (w == 100) begin
            nvec++; nerr++;
            $display("FAIL send_timeout: rx_ready=%b after %0d cycles, required 1", rx_ready, w);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input int nsend);
        logic [8*FLEN-1:0] fr;
        fr = {op, a, b};
        for (int i = 0; i < FLEN && i < nsend; i++) send_byte(fr[8*FLEN-1-8*i -: 8]);
    endtask

    // Entered at the negedge right after the last frame byte was accepted.
    task automatic recv_check(input string nm, input logic [7:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int stall_idx);
        logic [8*RLEN-1:0] exp;
        logic [7:0]        held;
        int                n;
        exp      = model(op, a, b);
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        n = 1;
        nvec++;
        if ({alu_m, alu_s, alu_a, alu_b, busy, rx_ready} !== {op[3:2], op[1:0], a, b, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL %s alu_drive: got m=%0d s=%0d a=%h b=%h busy=%b rdy=%b, required m=%0d s=%0d a=%h b=%h busy=1 rdy=0",
                     nm, alu_m, alu_s, alu_a, alu_b, busy, rx_ready, op[3:2], op[1:0], a, b);
        end
        while (!tx_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (n !== EC + 1) begin
            nerr++;
            $display("FAIL %s latency: got %0d cycles, required %0d", nm, n, EC + 1);
        end
        if (!tx_valid) return;
        for (int i = 0; i < RLEN; i++) begin
            if (i == stall_idx) begin
                tx_ready = 1'b0;
                held     = tx_data;
                for (int k = 0; k < 7; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    rx_valid = 1'b1;
                    rx_data  = 8'($urandom);
                    nvec++;
                    if ({tx_valid, tx_data, rx_ready} !== {1'b1, held, 1'b0}) begin
                        nerr++;
                        $display("FAIL %s stall_hold: got v=%b d=%h rdy=%b, required v=1 d=%h rdy=0",
                                 nm, tx_valid, tx_data, rx_ready, held);
                    end
                end
                rx_valid = 1'b0;
                tx_ready = 1'b1;
            end
            nvec++;
            if ({tx_valid, tx_data} !== {1'b1, exp[8*RLEN-1-8*i -: 8]}) begin
                nerr++;
                $display("FAIL %s rsp_byte%0d: got v=%b d=%h, required v=1 d=%h",
                         nm, i, tx_valid, tx_data, exp[8*RLEN-1-8*i -: 8]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        nvec++;
        if ({tx_valid, busy, rx_ready} !== 3'b001) begin
            nerr++;
            $display("FAIL %s frame_end: got v=%b busy=%b rdy=%b, required v=0 busy=0 rdy=1",
                     nm, tx_valid, busy, rx_ready);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h0F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({rx_ready, tx_valid, tx_data, busy, alu_m, alu_s, alu_a, alu_b} !== {1'b1, 1'b0, 8'h00, 1'b0, 68'h0}) begin
            nerr++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h busy=%b m=%0d s=%0d a=%h b=%h, required rdy=1 v=0 d=00 busy=0 alu=0",
                     rx_ready, tx_valid, tx_data, busy, alu_m, alu_s, alu_a, alu_b);
        end
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        nvec++;
        if ({busy, rx_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL reset_idle: got busy=%b rdy=%b, required busy=0 rdy=1", busy, rx_ready);
        end
    endtask

    task automatic test_add();
        send_frame(8'h00, 32'h5, 32'h3, FLEN);
        recv_check("add_5_3", 8'h00, 32'h5, 32'h3, -1);
    endtask

    task automatic test_flags();
        send_frame(8'h00, 32'h7FFF_FFFF, 32'h1, FLEN);
        recv_check("ovf", 8'h00, 32'h7FFF_FFFF, 32'h1, -1);
        send_frame(8'h00, 32'hFFFF_FFFF, 32'h1, FLEN);
        recv_check("zero", 8'h00, 32'hFFFF_FFFF, 32'h1, -1);
    endtask

    task automatic test_illegal();
        send_frame(8'h0F, 32'h1234_5678, 32'h9ABC_DEF0, FLEN);
        recv_check("illegal_0f", 8'h0F, 32'h1234_5678, 32'h9ABC_DEF0, -1);
        send_frame(8'hAA, 32'h1, 32'h2, FLEN);   // code 10: highest legal, upper nibble ignored
        recv_check("legal_0a", 8'hAA, 32'h1, 32'h2, -1);
        send_frame(8'h0B, 32'h1, 32'h2, FLEN);   // code 11: lowest illegal
        recv_check("illegal_0b", 8'h0B, 32'h1, 32'h2, -1);
    endtask

    task automatic test_random();
        logic [7:0]  op;
        logic [31:0] a, b;
        for (int t = 0; t < 12; t++) begin
            op = 8'($urandom);
            a  = $urandom;
            b  = (t % 4 == 3) ? (32'h0 - a) : $urandom;
            if (t % 4 == 1) begin
                a = {1'b0, a[30:0]} | 32'h4000_0000;
                b = {1'b0, b[30:0]} | 32'h4000_0000;
            end
            send_frame(op, a, b, FLEN);
            recv_check("random", op, a, b, -1);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        send_frame(8'h01, a, b, FLEN);
        recv_check("stall", 8'h01, a, b, 2);
    endtask

    task automatic test_back_to_back();
        // Prior frame ended at this negedge with rx_ready=1: the next byte must go at once.
        send_frame(8'h00, 32'h5, 32'h3, 1);
        nvec++;
        if (last_wait !== 0) begin
            nerr++;
            $display("FAIL b2b_first_byte: waited %0d cycles, required 0", last_wait);
        end
        send_frame(8'h00, 32'h0000_0005, 32'h0000_0003, 0);
        for (int i = 0; i < 2 * NB; i++) send_byte((i == NB - 1) ? 8'h05 : (i == 2 * NB - 1) ? 8'h03 : 8'h00);
        recv_check("b2b", 8'h00, 32'h5, 32'h3, -1);
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h00, 32'hDEAD_BEEF, 32'h1, 4);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nvec++;
        if ({busy, rx_ready, tx_valid} !== 3'b010) begin
            nerr++;
            $display("FAIL midreset_idle: got busy=%b rdy=%b v=%b, required busy=0 rdy=1 v=0", busy, rx_ready, tx_valid);
        end
        send_frame(8'h00, 32'h5, 32'h3, FLEN);
        recv_check("midreset", 8'h00, 32'h5, 32'h3, -1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) begin
                nvec++; nerr++;
                $display("FAIL midreset_extra_rsp: tx_valid=%b, required 0", tx_valid);
                break;
            end
        end
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL midreset_quiet: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_flags();
        test_illegal();
        test_back_to_back();
        test_random();
        test_stall();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_cmd_link.md
Name: alu_cmd_link

Overview:
- Byte-serial command front end for the 32-bit ALU (M, S select; add_sub_overflow and zero flags).
- Receives an opcode and two operands as a byte stream, presents them to the ALU, captures the result and flags, and returns them as a byte stream.
- Sits between a byte transport (UART or host bench) and the combinational ALU; this is the operand source and result sink for that ALU.

Parameters:
- DATA_W, 32, operand/result width in bits; must be a multiple of 8.
- NBYTES, DATA_W/8, bytes per operand/result (derived, not overridden).
- EXEC_CYCLES, 1, cycles operands are held stable before the result is sampled; range 1..15.
- MAX_OP, 10, highest legal {M,S} code; codes above it are illegal.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  inbound command byte
- rx_valid  in  1  inbound byte valid
- rx_ready  out  1  block accepts a byte this cycle
- tx_data  out  8  outbound response byte
- tx_valid  out  1  outbound byte valid
- tx_ready  in  1  sink accepts a byte
- alu_m  out  2  to ALU M
- alu_s  out  2  to ALU S
- alu_a  out  DATA_W  to ALU A
- alu_b  out  DATA_W  to ALU B
- alu_f  in  DATA_W  from ALU F
- alu_ovf  in  1  from ALU add_sub_overflow
- alu_zero  in  1  from ALU zero
- busy  out  1  high from first accepted byte until last response byte is accepted

Behaviour:
- Reset (rst_n low at a clk edge):
  - State RX_OP, byte counter 0.
  - rx_ready=1, tx_valid=0, tx_data=0, alu_m=0, alu_s=0, alu_a=0, alu_b=0, busy=0.
  - Reset mid-frame discards all partial data; no response is sent.
- Handshake:
  - A byte transfers on a clk edge where valid and ready are both high.
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - tx_valid is never dropped without a transfer.
- Command frame is 1+2*NBYTES bytes:
  - Opcode byte: bits[3:2]=M, bits[1:0]=S; bits[7:4] are ignored.
  - Operand A follows, MSB byte first, then operand B, MSB byte first.
- States:
  - RX_OP: rx_ready=1. On accept, latch the opcode, set busy=1, go to RX_A.
  - RX_A: rx_ready=1. Shift bytes into A; after NBYTES accepts go to RX_B.
  - RX_B: rx_ready=1. Shift bytes into B; after NBYTES accepts go to EXEC.
  - EXEC: rx_ready=0. alu_m/alu_s/alu_a/alu_b are driven from the latched values and held for EXEC_CYCLES cycles. At the final edge, capture alu_f, alu_ovf and alu_zero, then go to TX.
  - TX: rx_ready=0. Send 1+NBYTES bytes:
    - Flags byte = {5'b0, illegal, alu_ovf, alu_zero}.
    - Then F, MSB byte first.
    - After the last byte is accepted: busy=0, counter=0, go to RX_OP. alu_* outputs hold their last values.
- Illegal opcode ({M,S} > MAX_OP):
  - The frame is still fully received.
  - alu_* are driven as for a legal opcode.
  - The response reports illegal=1, ovf=0, zero=0, F=0.
- rx_ready is registered and is 0 in EXEC and TX; no input byte is lost or accepted there.
- Latency: the flags byte is presented (tx_valid=1) EXEC_CYCLES+1 cycles after the edge that accepts the last B byte.
- Back-to-back frames: rx_ready returns to 1 on the cycle after the last tx transfer. A byte presented in that cycle is accepted.
- tx_ready held low stalls TX indefinitely with no state change.
- The byte counter wraps to 0 at each state change.

Test Plan:
- Reset then idle: rst_n=0 for 2 edges while rx_valid=1 -> rx_ready=1, tx_valid=0, busy=0, all alu_* =0; no byte consumed.
- Bench ALU model F=A+B, ovf=signed overflow, zero=(F==0). Send opcode 0x00, A=0x00000005, B=0x00000003 -> alu_a=5, alu_b=3. Response bytes 0x00,0x00,0x00,0x00,0x08; first tx_valid EXEC_CYCLES+1 cycles after the last B byte.
- Send A=0x7FFFFFFF, B=0x00000001 -> response 0x02,0x80,0x00,0x00,0x00. Send A=0xFFFFFFFF, B=0x00000001 -> response 0x01,0x00,0x00,0x00,0x00.
- Opcode 0x0F with any operands -> alu_m=3, alu_s=3 driven; response 0x04,0x00,0x00,0x00,0x00.
- tx_ready low for 7 cycles during byte 2 of the response -> tx_data is held constant and tx_valid stays 1; rx_valid pulses are not accepted; the full 5-byte response completes correctly.
- Assert rst_n=0 after 4 bytes of a frame, then send a full new frame (5+3) -> only one response is produced, equal to 0x00,0x00,0x00,0x00,0x08.
